// File: rtl/alu_pipe_if.sv
// alu_pipe_if: issue-side and result-side handshake bundle for one ALU slot.
//   in_valid/in_ready   : op handshake from the issue queue
//   in_func/in_src1/in_src2/in_tag : op select, operands, ROB tag
//   out_valid/out_ready : result handshake towards the writeback/CDB arbiter
//   out_result/out_tag  : registered result and its ROB tag
// master = issue queue + consumer side, slave = the execution unit.
interface alu_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_func;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_func, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_func, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered integer execution unit for one issue slot.
//   clk, rst (sync, active-high), flush (kills in-flight op and held result)
//   bus : alu_pipe_if.slave carrying the op handshake (in_*) and the result
//         handshake (out_*).
// Single-cycle ops load the output register directly on accept. CLMUL/CLMULH
// run iteratively, CLMUL_BITS multiplier bits per cycle, then wait for a free
// output slot before delivering the low or high half of the product.
module alu_pipe #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 6,
  parameter int CLMUL_BITS = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  alu_pipe_if.slave bus
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int K     = XLEN / CLMUL_BITS;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [4:0] F_CLMUL  = 5'h1C;
  localparam logic [4:0] F_CLMULH = 5'h1D;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Bit-count helpers; results fit in SH_W+1 bits and are zero-extended.
  function automatic logic [SH_W:0] count_lz(input logic [XLEN-1:0] v);
    logic [SH_W:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) n = n + (SH_W+1)'(1);
    end
    return n;
  endfunction

  function automatic logic [SH_W:0] count_tz(input logic [XLEN-1:0] v);
    logic [SH_W:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) n = n + (SH_W+1)'(1);
    end
    return n;
  endfunction

  function automatic logic [SH_W:0] count_pop(input logic [XLEN-1:0] v);
    logic [SH_W:0] n;
    n = '0;
    for (int i = 0; i < XLEN; i++) n = n + (SH_W+1)'(v[i]);
    return n;
  endfunction

  function automatic logic [XLEN-1:0] zext_cnt(input logic [SH_W:0] c);
    return {{(XLEN-SH_W-1){1'b0}}, c};
  endfunction

  state_t            state_q, state_d;
  logic              vld_p1;
  logic [XLEN-1:0]   result_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [2*XLEN-1:0] acc_p0;
  logic [2*XLEN-1:0] mcand_p0;
  logic [XLEN-1:0]   mplier_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              hi_p0;
  logic [TAG_W-1:0]  ctag_p0;

  logic                   slot_free, ready, accept, is_clmul, last_step;
  logic [XLEN-1:0]        src1, src2, alu_res;
  logic signed [XLEN-1:0] src1_s, src2_s;
  logic [SH_W-1:0]        sh;
  logic [2*XLEN-1:0]      rot_l, rot_r, part;

  assign src1   = bus.in_src1;
  assign src2   = bus.in_src2;
  assign src1_s = bus.in_src1;
  assign src2_s = bus.in_src2;

  // out_ready feeds in_ready combinationally so a drain and a new accept can
  // share one edge; nothing from in_* reaches out_* without a register.
  assign slot_free = !vld_p1 || bus.out_ready;
  assign ready     = (state_q == S_IDLE) && slot_free && !flush && !rst;
  assign accept    = bus.in_valid && ready;
  assign is_clmul  = (bus.in_func == F_CLMUL) || (bus.in_func == F_CLMULH);
  assign last_step = (cnt_p0 == CNT_W'(K - 1));

  assign bus.in_ready   = ready;
  assign bus.out_valid  = vld_p1;
  assign bus.out_result = result_p1;
  assign bus.out_tag    = tag_p1;

  always_comb begin
    sh      = src2[SH_W-1:0];
    rot_l   = {src1, src1} << sh;
    rot_r   = {src1, src1} >> sh;
    alu_res = '0;
    case (bus.in_func)
      5'h00: alu_res = src1 & src2;
      5'h01: alu_res = src1 | src2;
      5'h02: alu_res = src1 ^ src2;
      5'h03: alu_res = src1 + src2;
      5'h04: alu_res = src1 - src2;
      5'h05: alu_res = {{(XLEN-1){1'b0}}, src1_s < src2_s};
      5'h06: alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
      5'h07: alu_res = {{(XLEN-1){1'b0}}, src1 >= src2};
      5'h08: alu_res = {{(XLEN-1){1'b0}}, src1_s >= src2_s};
      5'h09: alu_res = {{(XLEN-1){1'b0}}, src1 == src2};
      5'h0A: alu_res = {{(XLEN-1){1'b0}}, src1 != src2};
      5'h0B: alu_res = src1 >> sh;
      5'h0C: alu_res = src1_s >>> sh;
      5'h0D: alu_res = src1 << sh;
      5'h0E: alu_res = src1 + XLEN'(4);
      5'h0F: alu_res = src2;
      5'h10: alu_res = zext_cnt(count_lz(src1));
      5'h11: alu_res = zext_cnt(count_tz(src1));
      5'h12: alu_res = zext_cnt(count_pop(src1));
      5'h13: alu_res = (src1_s < src2_s) ? src1 : src2;
      5'h14: alu_res = (src1_s < src2_s) ? src2 : src1;
      5'h15: alu_res = (src1 < src2) ? src1 : src2;
      5'h16: alu_res = (src1 < src2) ? src2 : src1;
      5'h17: alu_res = rot_l[2*XLEN-1:XLEN];
      5'h18: alu_res = rot_r[XLEN-1:0];
      5'h19: alu_res = src1 & ~src2;
      5'h1A: alu_res = src1 | ~src2;
      5'h1B: alu_res = ~(src1 ^ src2);
      5'h1C, 5'h1D: alu_res = '0;
      default: alu_res = {(XLEN/32){32'hDEADBEEF}};
    endcase
  end

  // Partial product for the CLMUL_BITS multiplier bits handled this cycle;
  // mcand_p0 is pre-shifted so bit j of mplier_p0 maps to mcand_p0 << j.
  always_comb begin
    part = '0;
    for (int j = 0; j < CLMUL_BITS; j++) begin
      if (mplier_p0[j]) part = part ^ (mcand_p0 << j);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_clmul) state_d = S_BUSY;
      S_BUSY:  if (last_step)          state_d = S_DONE;
      S_DONE:  if (slot_free)          state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Stage p0: iterative carry-less multiply state.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0    <= '0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      cnt_p0    <= '0;
      hi_p0     <= 1'b0;
      ctag_p0   <= '0;
    end else if (accept && is_clmul) begin
      acc_p0    <= '0;
      mcand_p0  <= {{XLEN{1'b0}}, src1};
      mplier_p0 <= src2;
      cnt_p0    <= '0;
      hi_p0     <= bus.in_func[0];
      ctag_p0   <= bus.in_tag;
    end else if (state_q == S_BUSY) begin
      acc_p0    <= acc_p0 ^ part;
      mcand_p0  <= mcand_p0 << CLMUL_BITS;
      mplier_p0 <= mplier_p0 >> CLMUL_BITS;
      cnt_p0    <= cnt_p0 + CNT_W'(1);
    end
  end

  // Stage p1: output register, loaded by single-cycle ops or a finished CLMUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      tag_p1    <= '0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
    end else if (accept && !is_clmul) begin
      vld_p1    <= 1'b1;
      result_p1 <= alu_res;
      tag_p1    <= bus.in_tag;
    end else if ((state_q == S_DONE) && slot_free) begin
      vld_p1    <= 1'b1;
      result_p1 <= hi_p0 ? acc_p0[2*XLEN-1:XLEN] : acc_p0[XLEN-1:0];
      tag_p1    <= ctag_p0;
    end else if (bus.out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (XLEN=32 main instance plus a
// small XLEN=64 instance). A behavioural model tracks the output register,
// the CLMUL busy period and in_ready, and is compared every cycle; directed
// sequences pin the model with literal expectations.
module tb_alu_pipe;
  localparam int K = 32 / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush64 = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.XLEN(32), .TAG_W(6)) bus ();
  alu_pipe_if #(.XLEN(64), .TAG_W(6)) bus64 ();

  alu_pipe #(.XLEN(32), .TAG_W(6), .CLMUL_BITS(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );
  alu_pipe #(.XLEN(64), .TAG_W(6), .CLMUL_BITS(8)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64), .bus(bus64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result of one op, straight from the operation definitions.
  function automatic logic [63:0] ref_op(input int xl, input logic [4:0] f,
                                         input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0]  mask, a, b, r;
    longint       sa, sb;
    int           sh, n;
    logic [127:0] p;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a  = ai & mask;
    b  = bi & mask;
    sa = (xl == 64) ? longint'(a) : longint'({{32{a[31]}}, a[31:0]});
    sb = (xl == 64) ? longint'(b) : longint'({{32{b[31]}}, b[31:0]});
    sh = int'(b[5:0]) & (xl - 1);
    n  = 0;
    p  = '0;
    case (f)
      5'h00: r = a & b;
      5'h01: r = a | b;
      5'h02: r = a ^ b;
      5'h03: r = a + b;
      5'h04: r = a - b;
      5'h05: r = (sa < sb) ? 64'd1 : 64'd0;
      5'h06: r = (a < b) ? 64'd1 : 64'd0;
      5'h07: r = (a >= b) ? 64'd1 : 64'd0;
      5'h08: r = (sa >= sb) ? 64'd1 : 64'd0;
      5'h09: r = (a == b) ? 64'd1 : 64'd0;
      5'h0A: r = (a != b) ? 64'd1 : 64'd0;
      5'h0B: r = a >> sh;
      5'h0C: r = 64'(sa >>> sh);
      5'h0D: r = a << sh;
      5'h0E: r = a + 64'd4;
      5'h0F: r = b;
      5'h10: begin for (int i = xl - 1; i >= 0 && !a[i]; i--) n++; r = 64'(n); end
      5'h11: begin for (int i = 0; i < xl && !a[i]; i++) n++; r = 64'(n); end
      5'h12: begin for (int i = 0; i < xl; i++) n += int'(a[i]); r = 64'(n); end
      5'h13: r = (sa < sb) ? a : b;
      5'h14: r = (sa < sb) ? b : a;
      5'h15: r = (a < b) ? a : b;
      5'h16: r = (a < b) ? b : a;
      5'h17: r = (sh == 0) ? a : ((a << sh) | (a >> (xl - sh)));
      5'h18: r = (sh == 0) ? a : ((a >> sh) | (a << (xl - sh)));
      5'h19: r = a & ~b;
      5'h1A: r = a | ~b;
      5'h1B: r = ~(a ^ b);
      5'h1C, 5'h1D: begin
        for (int i = 0; i < xl; i++) if (b[i]) p = p ^ (128'(a) << i);
        r = (f == 5'h1D) ? 64'(p >> xl) : p[63:0];
      end
      default: r = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
    return r & mask;
  endfunction

  function automatic bit is_clm(input logic [4:0] f);
    return (f == 5'h1C) || (f == 5'h1D);
  endfunction

  // ---------------- behavioural model of the 32-bit instance ----------------
  bit          m_vld = 1'b0;
  logic [31:0] m_res;
  logic [5:0]  m_tag;
  int          m_busy = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_cres;
  logic [5:0]  m_ctag;

  function automatic bit m_free();
    return !m_vld || (bus.out_ready === 1'b1);
  endfunction

  function automatic bit m_ready();
    return (m_busy == 0) && !m_done && m_free() && !flush && !rst;
  endfunction

  function automatic bit m_fire();
    return (bus.in_valid === 1'b1) && m_ready();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_vld  <= 1'b0;
      m_res  <= '0;
      m_tag  <= '0;
      m_busy <= 0;
      m_done <= 1'b0;
    end else if (flush) begin
      m_vld  <= 1'b0;
      m_busy <= 0;
      m_done <= 1'b0;
    end else begin
      if (m_done && m_free()) begin
        m_vld  <= 1'b1;
        m_res  <= m_cres;
        m_tag  <= m_ctag;
        m_done <= 1'b0;
      end else if (m_fire() && !is_clm(bus.in_func)) begin
        m_vld <= 1'b1;
        m_res <= 32'(ref_op(32, bus.in_func, 64'(bus.in_src1), 64'(bus.in_src2)));
        m_tag <= bus.in_tag;
      end else if (bus.out_ready) begin
        m_vld <= 1'b0;
      end
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) m_done <= 1'b1;
      end
      if (m_fire() && is_clm(bus.in_func)) begin
        m_busy <= K;
        m_cres <= 32'(ref_op(32, bus.in_func, 64'(bus.in_src1), 64'(bus.in_src2)));
        m_ctag <= bus.in_tag;
      end
    end
  end

  always @(negedge clk) begin
    chk("model out_valid", 64'(bus.out_valid), 64'(m_vld));
    chk("model in_ready", 64'(bus.in_ready), 64'(m_ready()));
    if (m_vld) begin
      chk("model out_result", 64'(bus.out_result), 64'(m_res));
      chk("model out_tag", 64'(bus.out_tag), 64'(m_tag));
    end
  end

  // ------------------------------- stimulus --------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] t);
    bus.in_valid = v;
    bus.in_func  = f;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_tag   = t;
  endtask

  // Waits (bounded) for out_valid, leaving the caller at a negedge.
  task automatic wait_valid(input bit wide, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (wide ? bus64.out_valid : bus.out_valid) break;
    end
  endtask

  task automatic run64(input string name, input logic [4:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp);
    step();
    bus64.in_valid = 1'b1;
    bus64.in_func  = f;
    bus64.in_src1  = a;
    bus64.in_src2  = b;
    bus64.in_tag   = 6'h2A;
    step();
    bus64.in_valid = 1'b0;
    wait_valid(1'b1, 20);
    chk({name, " valid"}, 64'(bus64.out_valid), 64'd1);
    chk(name, bus64.out_result, exp);
    chk({name, " model"}, ref_op(64, f, a, b), exp);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0]  vf [21] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h15, 5'h18, 5'h1F, 5'h17,
                           5'h1B, 5'h08, 5'h06, 5'h0D, 5'h03, 5'h14, 5'h16, 5'h19,
                           5'h1A, 5'h0E, 5'h0F, 5'h10, 5'h12};
  logic [31:0] va [21] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'h1, 32'h0, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1,
                           32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0,
                           32'h0, 32'h10, 32'h5, 32'h00010000, 32'hF0};
  logic [31:0] vb [21] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h1, 32'h1, 32'h0, 32'h1,
                           32'h0, 32'h1, 32'hFFFFFFFF, 32'h21, 32'h2, 32'h1, 32'h1,
                           32'hFF00, 32'hFFFFFFFE, 32'h0, 32'h1234, 32'h0, 32'h0};
  logic [31:0] ve [21] = '{32'd32, 32'd32, 32'd32, 32'hFFFFFFFF, 32'h1, 32'h80000000,
                           32'hDEADBEEF, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2,
                           32'h1, 32'h1, 32'hFFFFFFFF, 32'h00F0, 32'h1, 32'h14,
                           32'h1234, 32'd15, 32'd4};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 5'h0, 32'h0, 32'h0, 6'h0);
    bus.out_ready   = 1'b1;
    bus64.in_valid  = 1'b0;
    bus64.in_func   = 5'h0;
    bus64.in_src1   = '0;
    bus64.in_src2   = '0;
    bus64.in_tag    = '0;
    bus64.out_ready = 1'b1;

    // Reset held for two edges.
    step();
    @(negedge clk);
    chk("rst in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_result", 64'(bus.out_result), 64'd0);
    chk("rst out_tag", 64'(bus.out_tag), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("post-rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("post-rst out_result64", bus64.out_result, 64'd0);

    // Back-to-back single-cycle ops.
    step();
    drive(1'b1, 5'h03, 32'h7FFFFFFF, 32'h1, 6'd3);
    @(negedge clk);
    chk("b2b ready0", 64'(bus.in_ready), 64'd1);
    step();
    drive(1'b1, 5'h0C, 32'h80000000, 32'h4, 6'd4);
    @(negedge clk);
    chk("b2b add result", 64'(bus.out_result), 64'h80000000);
    chk("b2b add tag", 64'(bus.out_tag), 64'd3);
    chk("b2b ready1", 64'(bus.in_ready), 64'd1);
    step();
    drive(1'b0, 5'h0, 32'h0, 32'h0, 6'h0);
    @(negedge clk);
    chk("b2b sra result", 64'(bus.out_result), 64'hF8000000);
    chk("b2b sra tag", 64'(bus.out_tag), 64'd4);

    // Single-cycle corner vectors.
    for (int i = 0; i < 21; i++) begin
      step();
      drive(1'b1, vf[i], va[i], vb[i], 6'(i));
      step();
      drive(1'b0, 5'h0, 32'h0, 32'h0, 6'h0);
      @(negedge clk);
      chk($sformatf("vec%0d f%0h result", i, vf[i]), 64'(bus.out_result), 64'(ve[i]));
      chk($sformatf("vec%0d model", i), ref_op(32, vf[i], 64'(va[i]), 64'(vb[i])), 64'(ve[i]));
    end

    // XLEN=64 instance.
    run64("x64 illegal", 5'h1F, 64'h0, 64'h0, 64'hDEADBEEF_DEADBEEF);
    run64("x64 add wrap", 5'h03, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0);
    run64("x64 clz", 5'h10, 64'h1, 64'h0, 64'd63);
    run64("x64 clmulh", 5'h1D, 64'h8000_0000_0000_0000, 64'h2, 64'h1);

    // CLMUL timing: accept at edge N, busy through cycle N+9, result in N+10.
    step();
    drive(1'b1, 5'h1C, 32'h80000003, 32'h80000003, 6'd5);
    step();
    drive(1'b0, 5'h0, 32'h0, 32'h0, 6'h0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk($sformatf("clmul busy ready c%0d", i), 64'(bus.in_ready), 64'd0);
      chk($sformatf("clmul busy valid c%0d", i), 64'(bus.out_valid), 64'd0);
    end
    @(negedge clk);
    chk("clmul valid", 64'(bus.out_valid), 64'd1);
    chk("clmul result", 64'(bus.out_result), 64'h00000005);
    chk("clmul tag", 64'(bus.out_tag), 64'd5);
    chk("clmul model", ref_op(32, 5'h1C, 64'h80000003, 64'h80000003), 64'h5);
    step();
    drive(1'b1, 5'h1D, 32'h80000003, 32'h80000003, 6'd6);
    step();
    drive(1'b0, 5'h0, 32'h0, 32'h0, 6'h0);
    wait_valid(1'b0, 20);
    chk("clmulh result", 64'(bus.out_result), 64'h40000000);
    chk("clmulh model", ref_op(32, 5'h1D, 64'h80000003, 64'h80000003), 64'h40000000);

    // Backpressure on a held ADD result, with another op presented.
    step();
    drive(1'b1, 5'h03, 32'h5, 32'h6, 6'd7);
    step();
    drive(1'b1, 5'h00, 32'hFF, 32'h0F, 6'd8);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp held result", 64'(bus.out_result), 64'hB);
      chk("bp held tag", 64'(bus.out_tag), 64'd7);
      chk("bp in_ready", 64'(bus.in_ready), 64'd0);
    end
    step();
    bus.out_ready = 1'b1;
    step();
    drive(1'b0, 5'h0, 32'h0, 32'h0, 6'h0);
    @(negedge clk);
    chk("bp next tag", 64'(bus.out_tag), 64'd8);
    chk("bp next result", 64'(bus.out_result), 64'h0F);

    // CLMUL completing while the consumer stalls.
    step();
    drive(1'b1, 5'h1C, 32'h3, 32'h3, 6'd9);
    step();
    drive(1'b0, 5'h0, 32'h0, 32'h0, 6'h0);
    bus.out_ready = 1'b0;
    wait_valid(1'b0, 20);
    chk("bp clmul result", 64'(bus.out_result), 64'h5);
    repeat (3) begin
      @(negedge clk);
      chk("bp clmul held", 64'(bus.out_valid), 64'd1);
    end
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp clmul pre-drain", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    chk("bp clmul drained", 64'(bus.out_valid), 64'd0);

    // Flush at cycle N+4 of a CLMUL while another op is presented.
    step();
    drive(1'b1, 5'h1C, 32'h80000003, 32'h80000003, 6'd10);
    step();
    drive(1'b1, 5'h03, 32'h1, 32'h1, 6'd11);
    step();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 5'h0, 32'h0, 32'h0, 6'h0);
    @(negedge clk);
    chk("flush in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("flush no result", 64'(bus.out_valid), 64'd0);
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      step();
      rst           = ($urandom_range(0, 199) == 0);
      flush         = ($urandom_range(0, 39) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), rnd_opnd(), rnd_opnd(),
            6'($urandom_range(0, 63)));
    end
    step();
    rst   = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 5'h0, 32'h0, 32'h0, 6'h0);
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered integer execution unit for one issue slot of the superscalar core.
- Extends the base RV32 ALU/bitmanip operation set to XLEN 32 or 64, adding MIN/MAX, rotates, ANDN/ORN/XNOR and iterative carry-less multiply.
- Uses valid/ready handshakes on both sides, carries a ROB tag, and supports a pipeline flush.
- Sits between the issue queue and the writeback/CDB arbiter.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- TAG_W, 6, width of the ROB tag carried with each op.
- CLMUL_BITS, 4, src2 bits consumed per cycle by CLMUL/CLMULH; must divide XLEN.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill the in-flight op and the held result.
- in_valid  input  1  op presented.
- in_ready  output  1  op accepted when in_valid && in_ready.
- in_func  input  5  operation select.
- in_src1  input  XLEN  operand 1.
- in_src2  input  XLEN  operand 2.
- in_tag  input  TAG_W  ROB tag.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes the result.
- out_result  output  XLEN  result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, out_valid=0, out_result=0, out_tag=0, CLMUL counter and accumulator=0. in_ready=0 while rst is high.
- Single-issue, in-order. Output register holds one result.
  - Output slot free = !out_valid || out_ready.
  - in_ready = (FSM==IDLE) && slot free && !flush && !rst.
- func[4]=0 (latency 1): 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLT (signed), 6 LTU, 7 GEU, 8 GE (signed), 9 EQ, A NE, B SRL, C SRA, D SLL, E src1+4, F pass src2.
  - Compares return 1 or 0, zero-extended.
  - Shift amount = src2[log2(XLEN)-1:0].
  - ADD/SUB wrap modulo 2^XLEN.
- func[4]=1: 0 CLZ, 1 CTZ, 2 CPOP, 3 MIN, 4 MAX, 5 MINU, 6 MAXU, 7 ROL, 8 ROR, 9 ANDN (src1&~src2), A ORN, B XNOR (latency 1); C CLMUL (low XLEN), D CLMULH (high XLEN) (multi-cycle).
  - Counts are zero-extended in a log2(XLEN)+1-bit field.
  - CLZ(0)=CTZ(0)=XLEN; CPOP(all ones)=XLEN. No saturation or wrap.
  - Rotate amount = src2[log2(XLEN)-1:0].
- Illegal func (1E, 1F): the result is 32'hDEADBEEF replicated XLEN/32 times, with latency 1. Not an exception.
- Latency-1 op accepted at edge N: out_valid=1, out_result and out_tag valid after edge N+1's preceding edge, i.e. visible in cycle N+1.
- Held result is stable until an edge where out_ready=1. A new op may be accepted in the same cycle it drains, giving back-to-back throughput of 1/cycle.
- CLMUL FSM: IDLE -> BUSY -> DONE -> IDLE.
  - Accept at edge N: latch operands, tag and func; acc=0; go BUSY.
  - BUSY lasts K=XLEN/CLMUL_BITS cycles. Each cycle, acc ^= src1 << j for each set bit j among the CLMUL_BITS bits processed, using a 2*XLEN accumulator.
  - After K cycles, go to DONE.
  - DONE: wait for a free output slot, then load the low or high half of acc plus the tag into the output register and return to IDLE.
  - Minimum latency: out_valid in cycle N+K+2. in_ready=0 throughout BUSY and DONE.
- Flush at an edge:
  - out_valid -> 0 and FSM -> IDLE (BUSY/DONE aborted, acc discarded).
  - No op is accepted at that edge.
  - out_result and out_tag may keep stale data.
  - Flush and rst together: rst wins (identical effect plus clearing of the data registers).
- rst mid-CLMUL: immediate return to IDLE; no result is ever produced for the aborted op.
- No combinational path from in_* to out_*. out_ready reaches in_ready combinationally only.

Test Plan:
- Reset: XLEN=32, rst held 2 cycles -> out_valid=0, out_result=0, FSM IDLE, in_ready=0 during rst and 1 after.
- Back-to-back: ADD 7FFFFFFF+1 (tag 3), then SRA 80000000>>4 (tag 4), out_ready=1 -> cycle N+1: 80000000/tag 3; cycle N+2: F8000000/tag 4; in_ready stays 1.
- Bitmanip corners:
  - CLZ(0)=32, CTZ(0)=32, CPOP(FFFFFFFF)=32.
  - MIN(FFFFFFFF,1)=FFFFFFFF; MINU(FFFFFFFF,1)=1.
  - ROR(00000001,1)=80000000.
  - func 1F -> DEADBEEF. With XLEN=64 -> DEADBEEFDEADBEEF.
- CLMUL: CLMUL_BITS=4, src1=src2=80000003.
  - CLMUL -> 00000005, out_valid in cycle N+10.
  - CLMULH -> 40000000.
  - in_ready=0 for cycles N+1..N+9.
- Backpressure: out_ready=0 for 5 cycles with a held ADD result -> out_result and out_tag stable, in_ready=0. A CLMUL finishing meanwhile waits in DONE and is delivered after the drain.
- Flush: flush at cycle N+4 of a CLMUL with in_valid=1 -> no result ever appears, the presented op is not accepted, FSM is IDLE, and in_ready=1 in cycle N+5.
